vc_allocator: RTL and testbench
===============================

# vc_allocator

Virtual-channel allocation stage serving every input-port VC buffer of the router. It takes VA-state requests and their routed output port, then assigns a free downstream VC on that output port using per-output-port round-robin arbitration. It returns a one-cycle `vc_valid_o`/`vc_new_o` grant and tracks downstream VC occupancy until the owning packet's tail leaves.

## Interface
- `PORT_NUM`, default 5: number of router ports, both input and output; indexed like `port_t`.
- `VC_NUM`, default 2: VCs per port, upstream and downstream.
- `VC_SIZE`, default $clog2(VC_NUM): width of a VC identifier.
- `clk`  in  1: clock; all state updates on rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `request_i`  in  [PORT_NUM][VC_NUM]: VA request per input VC; a buffer's `vc_request_o`.
- `out_port_i`  in  [PORT_NUM][VC_NUM] x port_t: routed output port per input VC; valid whenever the matching request is high.
- `release_i`  in  [PORT_NUM][VC_NUM]: downstream VC v of output port p is freed.
  - Driven from the input buffer's `vc_allocatable_o` together with its latched out_port/downstream_vc.
- `vc_valid_o`  out  [PORT_NUM][VC_NUM]: one-cycle grant pulse per input VC.
- `vc_new_o`  out  [PORT_NUM][VC_NUM] x VC_SIZE: granted downstream VC; meaningful only with `vc_valid_o`.
- `error_o`  out  1: one-cycle pulse on protocol violation.

## Operation
- State per output port p:
  - `avail[p][VC_NUM]`: downstream VC free flags.
  - `rr_ptr[p]`: index 0..PORT_NUM*VC_NUM-1 over flattened input VCs; flat index = in_port*VC_NUM + in_vc.
- Eligible requester for p: `request_i[i][v]` & `out_port_i[i][v]==p` & ~`vc_valid_o[i][v]`.
  - The last term masks a VC granted in the previous cycle. It still has its request asserted while its FSM leaves VA.
- Arbitration, per output port p, each cycle:
  - If any eligible requester exists and any `avail[p]` bit is 1, grant exactly one requester.
  - Winner: the first eligible flat index at or after `rr_ptr[p]`, wrapping modulo PORT_NUM*VC_NUM.
  - Assigned VC: the lowest-index v with `avail[p][v]=1`.
- Grant effects, registered at the same edge:
  - `vc_valid_o[winner]` = 1 and `vc_new_o[winner]` = assigned VC.
  - `avail[p][assigned]` = 0.
  - `rr_ptr[p]` = winner+1, with wrap.
- No grant: `rr_ptr[p]` holds.
- Maximum one grant per output port per cycle. Different output ports grant independently in the same cycle.
- An input VC belongs to one output port, so it can never receive two grants in one cycle.
- Release: `release_i[p][v]` sets `avail[p][v]` = 1 at the next edge.
  - A VC freed this cycle is not grantable until the following cycle, because arbitration uses the current-cycle `avail`.
- Error (pulse next cycle, otherwise no effect):
  - `release_i[p][v]` while `avail[p][v]` is already 1.
  - The set is not applied twice and the state is unchanged.
- All requests for p wait while `avail[p]` is all zero. There is no timeout and no request dropping.
- Outputs are registered and cleared every cycle with no new grant, so `vc_valid_o` is never high two consecutive cycles for the same VC.

## Timing
- Reset (`rst_n`=0, async): `avail` all 1, `rr_ptr` all 0, `vc_valid_o`=0, `vc_new_o`=0, `error_o`=0.
- Reset mid-operation discards all allocations. The input buffers are reset by the same event.
- Latency: request sampled at edge k -> `vc_valid_o` high during cycle k..k+1 (one cycle after request first visible), when a VC is free and the requester wins.
- Release at edge k -> VC grantable by arbitration in cycle after k -> grant visible one cycle later.
- Same cycle release_i[p][v] and grant on p: the grant uses only VCs free before the release. The released VC is available next cycle.
- Handshake: the buffer holds `vc_request_o` until it sees `vc_valid_o`. The allocator's mask covers the one overlap cycle.

## Test plan
- Single request after reset: `request_i[1][0]`=1, out_port=2.
  - -> `vc_valid_o[1][0]` pulses one cycle later with `vc_new_o`=0; `avail[2]`=2'b10.
  - No second pulse while request stays high one more cycle.
- Contention: input VCs [0][0], [3][1], [4][0] all request out_port 1 continuously, VC_NUM=2.
  - -> grants [0][0] (VC0) then [3][1] (VC1), then stall.
  - Release [1][0] -> [4][0] gets VC0 two cycles after the release.
- Round-robin fairness: two requesters re-requesting after each release.
  - -> grants alternate strictly. `rr_ptr` wraps from index 9 to 0.
- Parallel ports: requests to ports 0 and 3 in the same cycle -> both granted in the same cycle, both `vc_new_o`=0.
- Double release: `release_i[2][1]` with VC1 already free -> `error_o` one-cycle pulse; `avail` unchanged.
- Async reset mid-allocation: drop `rst_n` between edges with VCs held -> outputs 0 immediately; after release of reset, all VCs grantable again.

Source files
------------

// File: rtl/vc_allocator.sv
// Virtual-channel allocator: per output port, grants one free downstream VC to one
// eligible input VC per cycle using round-robin over flattened input VCs.
module vc_allocator #(
  parameter int PORT_NUM = 5,
  parameter int VC_NUM   = 2,
  parameter int VC_SIZE  = $clog2(VC_NUM),
  localparam int PORT_W  = (PORT_NUM > 1) ? $clog2(PORT_NUM) : 1
) (
  input  logic                                         clk,
  input  logic                                         rst_n,
  input  logic [PORT_NUM-1:0][VC_NUM-1:0]              request_i,
  input  logic [PORT_NUM-1:0][VC_NUM-1:0][PORT_W-1:0]  out_port_i,
  input  logic [PORT_NUM-1:0][VC_NUM-1:0]              release_i,
  output logic [PORT_NUM-1:0][VC_NUM-1:0]              vc_valid_o,
  output logic [PORT_NUM-1:0][VC_NUM-1:0][VC_SIZE-1:0] vc_new_o,
  output logic                                         error_o
);

  localparam int FLAT_NUM = PORT_NUM * VC_NUM;
  localparam int FLAT_W   = (FLAT_NUM > 1) ? $clog2(FLAT_NUM) : 1;
  localparam logic [FLAT_W:0]   FLAT_END  = (FLAT_W + 1)'(FLAT_NUM);
  localparam logic [FLAT_W-1:0] FLAT_LAST = FLAT_W'(FLAT_NUM - 1);

  logic [FLAT_NUM-1:0]                 req_flat_s;
  logic [FLAT_NUM-1:0]                 valid_flat_s;
  logic [FLAT_NUM-1:0][PORT_W-1:0]     port_flat_s;
  logic [PORT_NUM-1:0][FLAT_NUM-1:0]   elig_s;
  logic [PORT_NUM-1:0]                 grant_s;
  logic [PORT_NUM-1:0][FLAT_W-1:0]     win_s;
  logic [PORT_NUM-1:0][VC_SIZE-1:0]    vc_sel_s;
  logic [FLAT_W:0]                     sum_s;
  logic [FLAT_W:0]                     idx_s;
  logic                                hit_s;
  logic                                sel_s;

  logic [PORT_NUM-1:0][VC_NUM-1:0]     avail_r;
  logic [PORT_NUM-1:0][VC_NUM-1:0]     avail_nxt_s;
  logic [PORT_NUM-1:0][FLAT_W-1:0]     rr_ptr_r;
  logic [PORT_NUM-1:0][FLAT_W-1:0]     rr_ptr_nxt_s;
  logic [FLAT_NUM-1:0]                 valid_nxt_s;
  logic [FLAT_NUM-1:0][VC_SIZE-1:0]    new_nxt_s;
  logic                                error_nxt_s;

  // Flat index = in_port*VC_NUM + in_vc falls out of the packed layout directly.
  assign req_flat_s   = request_i;
  assign valid_flat_s = vc_valid_o;
  assign port_flat_s  = out_port_i;

  // Eligibility: requesting, routed to p, and not granted in the previous cycle.
  always_comb begin
    elig_s = '0;
    for (int p = 0; p < PORT_NUM; p++) begin
      for (int f = 0; f < FLAT_NUM; f++) begin
        elig_s[p][f] = req_flat_s[f] & ~valid_flat_s[f] & (port_flat_s[f] == PORT_W'(p));
      end
    end
  end

  // Round-robin winner search from rr_ptr and lowest free downstream VC per output port.
  always_comb begin
    grant_s  = '0;
    win_s    = '0;
    vc_sel_s = '0;
    sum_s    = '0;
    idx_s    = '0;
    hit_s    = 1'b0;
    for (int p = 0; p < PORT_NUM; p++) begin
      for (int k = 0; k < FLAT_NUM; k++) begin
        sum_s      = {1'b0, rr_ptr_r[p]} + (FLAT_W + 1)'(k);
        idx_s      = (sum_s >= FLAT_END) ? (sum_s - FLAT_END) : sum_s;
        hit_s      = ~grant_s[p] & elig_s[p][idx_s[FLAT_W-1:0]];
        win_s[p]   = hit_s ? idx_s[FLAT_W-1:0] : win_s[p];
        grant_s[p] = grant_s[p] | hit_s;
      end
      for (int v = VC_NUM - 1; v >= 0; v--) begin
        vc_sel_s[p] = avail_r[p][v] ? VC_SIZE'(v) : vc_sel_s[p];
      end
      grant_s[p] = grant_s[p] & (|avail_r[p]);
    end
  end

  // Next-state: releases land after arbitration, so a freed VC is grantable next cycle.
  always_comb begin
    avail_nxt_s  = avail_r | release_i;
    rr_ptr_nxt_s = rr_ptr_r;
    valid_nxt_s  = '0;
    new_nxt_s    = '0;
    sel_s        = 1'b0;
    error_nxt_s  = |(avail_r & release_i);
    for (int p = 0; p < PORT_NUM; p++) begin
      avail_nxt_s[p][vc_sel_s[p]] = avail_nxt_s[p][vc_sel_s[p]] & ~grant_s[p];
      rr_ptr_nxt_s[p] = grant_s[p] ?
                        ((win_s[p] == FLAT_LAST) ? '0 : (win_s[p] + FLAT_W'(1))) :
                        rr_ptr_r[p];
      for (int f = 0; f < FLAT_NUM; f++) begin
        sel_s          = grant_s[p] & (win_s[p] == FLAT_W'(f));
        valid_nxt_s[f] = valid_nxt_s[f] | sel_s;
        new_nxt_s[f]   = sel_s ? vc_sel_s[p] : new_nxt_s[f];
      end
    end
  end

  // State and registered grant/error outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      avail_r    <= '1;
      rr_ptr_r   <= '0;
      vc_valid_o <= '0;
      vc_new_o   <= '0;
      error_o    <= 1'b0;
    end else begin
      avail_r    <= avail_nxt_s;
      rr_ptr_r   <= rr_ptr_nxt_s;
      vc_valid_o <= valid_nxt_s;
      vc_new_o   <= new_nxt_s;
      error_o    <= error_nxt_s;
    end
  end

endmodule

// File: tb/tb_vc_allocator.sv
// Directed self-checking bench for vc_allocator with default parameters (5 ports, 2 VCs).
module tb_vc_allocator;

  localparam int PORT_NUM = 5;
  localparam int VC_NUM   = 2;
  localparam int VC_SIZE  = 1;
  localparam int PORT_W   = 3;

  logic clk = 1'b0;
  logic rst_n;
  logic [PORT_NUM-1:0][VC_NUM-1:0]              request;
  logic [PORT_NUM-1:0][VC_NUM-1:0][PORT_W-1:0]  out_port;
  logic [PORT_NUM-1:0][VC_NUM-1:0]              rel;
  logic [PORT_NUM-1:0][VC_NUM-1:0]              vc_valid;
  logic [PORT_NUM-1:0][VC_NUM-1:0][VC_SIZE-1:0] vc_new;
  logic                                         error;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  vc_allocator #(.PORT_NUM(PORT_NUM), .VC_NUM(VC_NUM), .VC_SIZE(VC_SIZE)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .request_i  (request),
    .out_port_i (out_port),
    .release_i  (rel),
    .vc_valid_o (vc_valid),
    .vc_new_o   (vc_new),
    .error_o    (error)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    request  = '0;
    out_port = '0;
    rel      = '0;
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    idle_inputs();
    #2 rst_n = 1'b1;
  endtask

  task automatic ask(input int i, input int v, input int p);
    request[i][v]  = 1'b1;
    out_port[i][v] = PORT_W'(p);
  endtask

  initial begin
    rst_n = 1'b1;
    idle_inputs();
    #1 rst_n = 1'b0;
    #2;
    check("reset_valid", 32'(vc_valid), 32'd0);
    check("reset_new",   32'(vc_new),   32'd0);
    check("reset_error", 32'(error),    32'd0);
    #8 rst_n = 1'b1;

    // Single request, then the masked overlap cycle.
    ask(1, 0, 2);
    tick();
    check("single_valid", 32'(vc_valid), 32'd1 << 2);
    check("single_new",   32'(vc_new[1][0]), 32'd0);
    tick();
    check("single_mask",  32'(vc_valid), 32'd0);
    request[1][0] = 1'b0;
    ask(2, 1, 2);
    tick();
    check("second_valid", 32'(vc_valid), 32'd1 << 5);
    check("second_new",   32'(vc_new[2][1]), 32'd1);
    request[2][1] = 1'b0;

    // Legal release, then a double release of the same VC.
    rel[2][1] = 1'b1;
    tick();
    check("rel_ok_err", 32'(error), 32'd0);
    tick();
    check("dbl_rel_err", 32'(error), 32'd1);
    rel = '0;
    tick();
    check("err_pulse", 32'(error), 32'd0);
    ask(0, 0, 2);
    tick();
    check("after_dbl_valid", 32'(vc_valid), 32'd1 << 0);
    check("after_dbl_new",   32'(vc_new[0][0]), 32'd1);

    // Contention on output port 1.
    do_reset();
    ask(0, 0, 1);
    ask(3, 1, 1);
    ask(4, 0, 1);
    tick();
    check("cont_g1_valid", 32'(vc_valid), 32'd1 << 0);
    check("cont_g1_new",   32'(vc_new[0][0]), 32'd0);
    tick();
    check("cont_g2_valid", 32'(vc_valid), 32'd1 << 7);
    check("cont_g2_new",   32'(vc_new[3][1]), 32'd1);
    request[0][0] = 1'b0;
    tick();
    check("cont_stall1", 32'(vc_valid), 32'd0);
    request[3][1] = 1'b0;
    tick();
    check("cont_stall2", 32'(vc_valid), 32'd0);
    rel[1][0] = 1'b1;
    tick();
    rel = '0;
    check("cont_rel_same", 32'(vc_valid), 32'd0);
    tick();
    check("cont_g3_valid", 32'(vc_valid), 32'd1 << 8);
    check("cont_g3_new",   32'(vc_new[4][0]), 32'd0);

    // Round-robin: fill port 4, then two requesters share one recycled VC.
    do_reset();
    ask(2, 0, 4);
    tick();
    check("rr_fill0", 32'(vc_valid), 32'd1 << 4);
    request[2][0] = 1'b0;
    ask(3, 0, 4);
    tick();
    check("rr_fill1", 32'(vc_valid), 32'd1 << 6);
    check("rr_fill1_new", 32'(vc_new[3][0]), 32'd1);
    request[3][0] = 1'b0;
    ask(0, 1, 4);
    ask(4, 1, 4);
    for (int r = 0; r < 4; r++) begin
      rel[4][0] = 1'b1;
      tick();
      rel[4][0] = 1'b0;
      check("rr_rel_cycle", 32'(vc_valid), 32'd0);
      tick();
      check("rr_winner", 32'(vc_valid), (r % 2 == 0) ? (32'd1 << 9) : (32'd1 << 1));
      check("rr_new", (r % 2 == 0) ? 32'(vc_new[4][1]) : 32'(vc_new[0][1]), 32'd0);
    end

    // Parallel ports, then async reset while a grant is visible.
    do_reset();
    ask(1, 1, 0);
    ask(2, 0, 3);
    tick();
    check("par_valid", 32'(vc_valid), (32'd1 << 3) | (32'd1 << 4));
    check("par_new0",  32'(vc_new[1][1]), 32'd0);
    check("par_new3",  32'(vc_new[2][0]), 32'd0);
    idle_inputs();
    ask(3, 0, 0);
    tick();
    check("pre_rst_valid", 32'(vc_valid), 32'd1 << 6);
    check("pre_rst_new",   32'(vc_new[3][0]), 32'd1);
    #2 rst_n = 1'b0;
    idle_inputs();
    #1;
    check("rst_valid", 32'(vc_valid), 32'd0);
    check("rst_new",   32'(vc_new), 32'd0);
    #2 rst_n = 1'b1;
    ask(3, 0, 0);
    ask(2, 0, 3);
    tick();
    check("post_rst_valid", 32'(vc_valid), (32'd1 << 6) | (32'd1 << 4));
    check("post_rst_new0",  32'(vc_new[3][0]), 32'd0);
    check("post_rst_new3",  32'(vc_new[2][0]), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
